// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-through, no-write-allocate data cache
`timescale 1ns/1ps
module cache_nway #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SETS          = 8,
  parameter int WAYS          = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_ready,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     hit,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);
  localparam int SW = $clog2(SETS);
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int TW = ADDRESS_WIDTH - 2 - SW;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;
  state_t st, nxt;
  logic [ADDRESS_WIDTH-1:2] addr_q, cur_addr;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     hit_q, hit_any, inv_any;
  logic [WW-1:0]            way_q, hit_way, vic;
  logic [SW-1:0]            set_i;
  logic [TW-1:0]            tag_i;
  logic [WW-1:0]            rr [SETS];
  logic [WAYS-1:0]          valid [SETS];
  logic [TW-1:0]            tag_mem [SETS][WAYS];
  logic [DATA_WIDTH-1:0]    data_mem [SETS][WAYS];
  logic                     unused_ok;
  assign unused_ok = ^cpu_addr[1:0];
  // Lookup uses the live request in IDLE and the latched one while a transaction is open.
  always_comb begin
    cur_addr = st == IDLE ? cpu_addr[ADDRESS_WIDTH-1:2] : addr_q;
    set_i    = cur_addr[2 +: SW];
    tag_i    = cur_addr[ADDRESS_WIDTH-1 -: TW];
    hit_any  = 1'b0;
    hit_way  = '0;
    inv_any  = 1'b0;
    vic      = rr[set_i];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[set_i][w] && tag_mem[set_i][w] == tag_i) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid[set_i][w]) begin
        inv_any = 1'b1;
        vic     = WW'(w);
      end
    end
  end
  always_comb begin
    nxt = st;
    if (st == IDLE)
      nxt = (cpu_req && !flush) ? (cpu_we ? WR_THRU : (hit_any ? RESP : RD_MISS)) : IDLE;
    else if (st == RESP)
      nxt = IDLE;
    else if (mem_ack)
      nxt = RESP;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  assign cpu_ready = st == RESP;
  assign mem_req   = st == RD_MISS || st == WR_THRU;
  assign mem_we    = st == WR_THRU;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      hit_q     <= 1'b0;
      way_q     <= '0;
      cpu_rdata <= '0;
      hit       <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else if (st == IDLE && flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else if (st == IDLE && cpu_req) begin
      addr_q  <= cpu_addr[ADDRESS_WIDTH-1:2];
      wdata_q <= cpu_wdata;
      hit_q   <= hit_any;
      way_q   <= hit_way;
      if (!cpu_we && hit_any) begin
        cpu_rdata <= data_mem[set_i][hit_way];
        hit       <= 1'b1;
      end
    end else if (st == RD_MISS && mem_ack) begin
      valid[set_i][vic] <= 1'b1;
      if (!inv_any) rr[set_i] <= WW'((int'(rr[set_i]) + 1) % WAYS);
      cpu_rdata <= mem_rdata;
      hit       <= 1'b0;
    end else if (st == WR_THRU && mem_ack) begin
      hit <= hit_q;
    end
  // Tag/data storage carries no reset; validity alone qualifies its contents.
  always_ff @(posedge clk)
    if (st == RD_MISS && mem_ack) begin
      tag_mem[set_i][vic]  <= tag_i;
      data_mem[set_i][vic] <= mem_rdata;
    end else if (st == WR_THRU && mem_ack && hit_q) begin
      data_mem[set_i][way_q] <= wdata_q;
    end
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: scoreboard bench for cache_nway with a delayed-ack memory model
`timescale 1ns/1ps
module tb_cache_nway;
  logic clk = 0, rst = 0, flush = 0, cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic cpu_ready, hit, mem_req, mem_we;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic mem_ack = 0;
  logic [31:0] mem_rdata = 0;
  int checks = 0, failures = 0;
  int ack_dly = 1, req_cnt = 0, req_cycles = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic cap_we;
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  typedef struct {logic we; logic hit; logic [31:0] data;} exp_t;
  exp_t exp_q [$];

  cache_nway dut (
    .clk(clk), .rst(rst), .flush(flush), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .hit(hit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // Memory device: acks after ack_dly request cycles, applies writes.
  always @(negedge clk) begin
    if (mem_ack) mem_ack = 0;
    else if (mem_req) begin
      req_cycles++;
      req_cnt++;
      cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
      if (req_cnt >= ack_dly) begin
        mem_ack = 1;
        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        req_cnt = 0;
      end
    end else req_cnt = 0;
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_hit, input int dly, input logic b2b, input logic fl,
                        input string nm);
    exp_t e;
    logic [31:0] wa;
    logic mem_exp;
    int lat, exp_lat;
    wa = a & 32'hFFFF_FFFC;
    e.we = we; e.hit = exp_hit;
    e.data = ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa);
    if (we) ref_mem[wa] = d;
    exp_q.push_back(e);
    mem_exp = we || !exp_hit;
    exp_lat = (mem_exp ? dly : 0) + 1 + int'(b2b) + int'(fl);
    ack_dly = dly;
    if (!b2b) @(negedge clk);
    req_cycles = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; flush = fl;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (fl && lat == 1) begin
        flush = 0;
        checks++;
        if (mem_req !== 0 || cpu_ready !== 0) begin
          failures++;
          $display("FAIL %s flush_same_cycle: mem_req=%b cpu_ready=%b want 0 0", nm, mem_req, cpu_ready);
        end
      end
    end while (!cpu_ready && lat < 200);
    cpu_req = 0;
    e = exp_q.pop_front();
    checks++;
    if (cpu_ready !== 1) begin
      failures++;
      $display("FAIL %s timeout: cpu_ready=%b want 1", nm, cpu_ready);
      return;
    end
    checks++;
    if (hit !== e.hit) begin
      failures++;
      $display("FAIL %s hit: got %b want %b", nm, hit, e.hit);
    end
    if (!e.we) begin
      checks++;
      if (cpu_rdata !== e.data) begin
        failures++;
        $display("FAIL %s rdata: got %h want %h", nm, cpu_rdata, e.data);
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
    end
    checks++;
    if (req_cycles !== (mem_exp ? dly : 0)) begin
      failures++;
      $display("FAIL %s mem_req_cycles: got %0d want %0d", nm, req_cycles, mem_exp ? dly : 0);
    end
    if (mem_exp) begin
      checks++;
      if (cap_addr !== wa || cap_we !== we || (we && cap_wdata !== d)) begin
        failures++;
        $display("FAIL %s mem_bus: addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                 nm, cap_addr, cap_we, cap_wdata, wa, we, d);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({cpu_ready, hit, mem_req, mem_we} !== 4'b0 || cpu_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      failures++;
      $display("FAIL %s reset_outputs: ready=%b hit=%b req=%b we=%b rdata=%h addr=%h wdata=%h want all 0",
               nm, cpu_ready, hit, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset;
    #1 check_zero("reset_t0");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    rst = 1;
  endtask

  task automatic test_miss_refill;
    access(0, 32'h40, 0, 0, 3, 0, 0, "load40_miss");
    access(0, 32'h43, 0, 1, 1, 0, 0, "load40_hit");
  endtask

  task automatic test_replacement;
    access(0, 32'h60, 0, 0, 2, 0, 0, "load60_miss");
    access(0, 32'h80, 0, 0, 1, 0, 0, "load80_evict40");
    access(0, 32'h60, 0, 1, 1, 0, 0, "load60_hit");
    access(0, 32'h40, 0, 0, 1, 0, 0, "load40_miss_evicted");
  endtask

  task automatic test_store;
    access(0, 32'h60, 0, 0, 1, 0, 0, "load60_refetch");
    access(1, 32'h60, 32'h1234_5678, 1, 2, 0, 0, "store60_hit");
    access(0, 32'h60, 0, 1, 1, 0, 0, "load60_after_store");
    access(1, 32'hA0, 32'hCAFE_F00D, 0, 1, 0, 0, "storeA0_miss");
    access(0, 32'hA0, 0, 0, 2, 0, 0, "loadA0_miss");
    access(0, 32'h60, 0, 1, 1, 0, 0, "load60_still_hit");
  endtask

  task automatic test_flush;
    @(negedge clk) flush = 1;
    @(negedge clk) flush = 0;
    access(0, 32'h60, 0, 0, 1, 0, 0, "load60_after_flush");
    access(0, 32'h60, 0, 1, 1, 0, 0, "load60_hit_after_refill");
    access(0, 32'h60, 0, 0, 2, 0, 1, "load60_with_flush");
  endtask

  task automatic test_back_to_back;
    access(0, 32'h0C, 0, 0, 1, 0, 0, "b2b_0C_miss");
    access(0, 32'h2C, 0, 0, 2, 1, 0, "b2b_2C_miss");
    access(0, 32'h0C, 0, 1, 1, 1, 0, "b2b_0C_hit");
    access(0, 32'h2C, 0, 1, 1, 1, 0, "b2b_2C_hit");
    access(1, 32'h0C, 32'h0BAD_CAFE, 1, 1, 1, 0, "b2b_store_0C");
    access(0, 32'h0C, 0, 1, 1, 1, 0, "b2b_0C_hit_new");
  endtask

  task automatic test_mid_reset;
    access(0, 32'h44, 0, 0, 1, 0, 0, "load44_miss");
    access(0, 32'h44, 0, 1, 1, 0, 0, "load44_hit");
    ack_dly = 1000;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h48;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h48) begin
      failures++;
      $display("FAIL mid_reset_pending: mem_req=%b addr=%h want 1 00000048", mem_req, mem_addr);
    end
    #2 rst = 0;
    #1 check_zero("mid_reset");
    cpu_req = 0;
    @(negedge clk) rst = 1;
    access(0, 32'h44, 0, 0, 1, 0, 0, "load44_after_reset");
    access(0, 32'h48, 0, 0, 2, 0, 0, "load48_after_reset");
  endtask

  initial begin
    mem_arr[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    test_reset;
    test_miss_refill;
    test_replacement;
    test_store;
    test_flush;
    test_back_to_back;
    test_mid_reset;
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
